// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexes a 4-digit packed BCD value onto a common-anode display. It feeds a
//   BCD-to-seven-segment decoder that has a one-cycle registered output. The anode
//   enables are delayed one cycle more than bcd, so the decoder's segments and these
//   anodes change in the same cycle.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   en          in   display enable; low blanks all digits (timing keeps running)
//   value_in    in   [15:0] packed BCD, [3:0] = digit 0 (an[0], rightmost)
//   bcd         out  [3:0] registered digit code to decoder, 4'hF = blank
//   an          out  [3:0] registered active-low anode enables
//   frame_start out  one-cycle pulse when a new frame begins and value_in is captured
//
// Optional feature
//   LEADING_ZERO_BLANK_EN: when defined, leading zero digits 3..1 are blanked.
//   Digit 0 is never blanked.

module display_scan_ctrl #(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned DIV_W    = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] value_in,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam logic [DIV_W-1:0] DivMax = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_digit_idx;
  logic [1:0]       r_idx_d1;
  logic [15:0]      r_shadow;
  logic             r_en_d1;
  logic [3:0]       r_bcd;
  logic [3:0]       r_an;
  logic             r_frame_start;

  logic             w_tick;
  logic             w_frame_end;
  logic [3:0]       w_nibble;
  logic [3:0]       w_digit;

  assign w_tick      = (r_div_cnt == DivMax);
  assign w_frame_end = w_tick && (r_digit_idx == 2'd3);

  always_comb begin
    w_nibble = r_shadow[3:0];
    unique case (r_digit_idx)
      2'd0: w_nibble = r_shadow[3:0];
      2'd1: w_nibble = r_shadow[7:4];
      2'd2: w_nibble = r_shadow[11:8];
      2'd3: w_nibble = r_shadow[15:12];
      default: w_nibble = r_shadow[3:0];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Digit k is blanked when it and every digit to its left are zero. Using the shadow
  // copy keeps the decision stable for the whole frame.
  logic [3:1] w_lead_zero;
  assign w_lead_zero[3] = (r_shadow[15:12] == 4'h0);
  assign w_lead_zero[2] = (r_shadow[15:8] == 8'h00);
  assign w_lead_zero[1] = (r_shadow[15:4] == 12'h000);

  always_comb begin
    w_digit = w_nibble;
    unique case (r_digit_idx)
      2'd1: if (w_lead_zero[1]) w_digit = 4'hF;
      2'd2: if (w_lead_zero[2]) w_digit = 4'hF;
      2'd3: if (w_lead_zero[3]) w_digit = 4'hF;
      default: w_digit = w_nibble;
    endcase
  end
`else
  assign w_digit = w_nibble;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt     <= '0;
      r_digit_idx   <= 2'd0;
      r_idx_d1      <= 2'd0;
      r_shadow      <= 16'h0000;
      r_en_d1       <= 1'b0;
      r_bcd         <= 4'hF;
      r_an          <= 4'b1111;
      r_frame_start <= 1'b0;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      if (w_tick) begin
        r_digit_idx <= r_digit_idx + 2'd1;
      end
      // value_in is sampled only here, so mid-frame changes cannot tear the display.
      if (w_frame_end) begin
        r_shadow <= value_in;
      end
      r_frame_start <= w_frame_end;
      // bcd uses the pre-capture shadow on the capture edge.
      r_bcd    <= en ? w_digit : 4'hF;
      r_idx_d1 <= r_digit_idx;
      r_en_d1  <= en;
      // One extra stage on the anodes to line up with the decoder's registered segments.
      r_an     <= r_en_d1 ? ~(4'b0001 << r_idx_d1) : 4'b1111;
    end
  end

  assign bcd         = r_bcd;
  assign an          = r_an;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

  localparam int unsigned Tick  = 4;
  localparam int unsigned DivW  = 3;
  localparam int unsigned Slot  = Tick;
  localparam int unsigned Frame = 4 * Tick;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] value_in;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        frame_start;

  bit          clk_run;
  int          checks;
  int          failures;

  // Stimulus history, indexed by clock edge number since the last reset release.
  int          n_edge;
  logic [15:0] val_at[0:4095];
  bit          en_at[0:4095];

  typedef struct packed {
    logic [3:0] bcd;
    logic [3:0] an;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];

  display_scan_ctrl #(
    .TICK_DIV(Tick),
    .DIV_W   (DivW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .value_in   (value_in),
    .bcd        (bcd),
    .an         (an),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  // Digit shown for slot d, given the frame's captured value.
  function automatic logic [3:0] digit_of(input logic [15:0] sh, input int d);
    logic [3:0] nib;
    bit         blank;
    nib   = sh[4*d +: 4];
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0) begin
      blank = 1'b1;
      for (int k = d; k < 4; k++) begin
        if (sh[4*k +: 4] != 4'h0) blank = 1'b0;
      end
    end
`endif
    return blank ? 4'hF : nib;
  endfunction

  // Expected outputs just after edge n. Slot timing is derived from edge counts:
  // the digit index after edge m is (m/Slot)%4 and the frame is m/Frame.
  function automatic exp_t expect_at(input int n);
    exp_t        e;
    int          s;
    int          f;
    logic [15:0] sh;
    s  = n - 1;
    f  = s / Frame;
    sh = (f == 0) ? 16'h0000 : val_at[f * Frame];
    e.bcd = en_at[n] ? digit_of(sh, (s / Slot) % 4) : 4'hF;
    if (n < 2 || !en_at[n - 1]) e.an = 4'b1111;
    else                        e.an = ~(4'b0001 << ((n - 2) / Slot) % 4);
    e.fs = (n % Frame) == 0;
    return e;
  endfunction

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%h expected=%h", tag, n_edge, obs, expv);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, n_edge, obs, expv);
    end
  endtask

  // Advance k clocks; push the expectation when inputs are committed, pop after the edge.
  task automatic step(input int k);
    exp_t e;
    for (int i = 0; i < k; i++) begin
      n_edge++;
      val_at[n_edge] = value_in;
      en_at[n_edge]  = en;
      exp_q.push_back(expect_at(n_edge));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check4("bcd", bcd, e.bcd);
      check4("an", an, e.an);
      check1("frame_start", frame_start, e.fs);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    n_edge = 0;
    #4;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    n_edge   = 0;
    clk_run  = 1'b0;
    en       = 1'b1;
    value_in = 16'h1234;
    rst_n    = 1'b1;

    // Async reset with no clock running.
    #3 rst_n = 1'b0;
    #1;
    check4("rst_an", an, 4'b1111);
    check4("rst_bcd", bcd, 4'hF);
    check1("rst_fs", frame_start, 1'b0);

    clk_run = 1'b1;
    #20;
    release_reset();

    // Frame 0 shows 0000, then 1234 for two frames; value changes mid digit-1 slot later.
    step(2 * Frame + Slot + 1);
    value_in = 16'h5678;
    step(2 * Frame);

    // Leading zeros and all-zero value.
    value_in = 16'h0042;
    step(2 * Frame);
    value_in = 16'h0000;
    step(2 * Frame);

    // Enable dropped mid-slot, then restored.
    value_in = 16'h1234;
    step(Frame + 2);
    en = 1'b0;
    step(Frame + 3);
    en = 1'b1;
    step(Frame);

    // Invalid digits pass through.
    value_in = 16'hA9F0;
    step(2 * Frame + Slot + 1);

    // Async reset between clock edges.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check4("async_rst_an", an, 4'b1111);
    check4("async_rst_bcd", bcd, 4'hF);
    check1("async_rst_fs", frame_start, 1'b0);
    exp_q.delete();
    #20;
    release_reset();
    value_in = 16'h0915;
    step(2 * Frame + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Upstream neighbour of the BCD-to-seven-segment decoder on the 4-digit common-anode display.
- Holds a 4-digit packed BCD value and time-multiplexes it one digit at a time.
- Drives the decoder's 4-bit bcd input and the active-low anode enables.
- Anode timing is compensated for the decoder's one-cycle registered output, so segments and anodes change in the same cycle.

Parameters:
- TICK_DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range 2..2^24.
- DIV_W, 17: width of the slot divider; must satisfy 2^DIV_W >= TICK_DIV.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  display enable; low blanks all digits.
- value_in  input  16  packed BCD; [3:0] = digit 0 (rightmost, an[0]) ... [15:12] = digit 3 (leftmost, an[3]).
- bcd  output  4  registered digit code to the decoder; 4'hF = blank.
- an  output  4  registered active-low anode enables; at most one bit low.
- frame_start  output  1  one-cycle pulse when a new frame begins and value_in is captured.

Behaviour:
- Reset (async, rst_n low, no clock needed): div_cnt=0, digit_idx=0, idx_d1=0, shadow=16'h0000, bcd=4'hF, an=4'b1111, frame_start=0.
- Divider: div_cnt counts 0..TICK_DIV-1 and wraps to 0. tick = (div_cnt==TICK_DIV-1).
- Digit index: on tick, digit_idx <= digit_idx+1 mod 4 (2-bit wrap 3->0). It holds otherwise.
- Frame latch: on tick with digit_idx==3, shadow <= value_in and frame_start=1 on the next cycle, aligned with digit_idx becoming 0.
  - value_in is never sampled at any other time, so a mid-frame change cannot tear the display.
  - The first frame after reset shows shadow=0000.
- Pipeline, per cycle:
  - bcd <= en ? sel(shadow, digit_idx) : 4'hF, where sel picks nibble digit_idx (optionally blanked, see below).
  - idx_d1 <= digit_idx.
  - an <= en_d1 ? ~(4'b0001 << idx_d1) : 4'b1111, where en_d1 is en delayed one cycle.
  - Result: bcd lags digit_idx by 1 cycle; an lags by 2 cycles. This matches decoder seg, which lags bcd by 1 cycle.
- Nibbles A-F in value_in are passed through unchanged; the decoder blanks them.
- en is independent of timing: the divider, digit_idx and frame latch keep running while en=0. Re-asserting en resumes on the current slot with no restart.
- Simultaneous events: tick and frame capture in the same cycle are the same event. The bcd update in that cycle uses the old shadow; the new shadow appears in the following cycle's bcd.
- Reset mid-frame: all state returns to reset values immediately. Scanning restarts at digit 0 with a full slot after rst_n rises.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: digit k (k=3,2,1) outputs bcd=4'hF when shadow nibbles k..3 are all zero.
  - Digit 0 is never blanked by this rule, so 0000 displays "0".
  - Blank decisions use shadow, so they are frame-stable.
- Not defined: all four nibbles are displayed as-is; zeros show as "0".

Test Plan:
1. Reset: rst_n=0 with clk stopped -> an=1111, bcd=F immediately. Release with TICK_DIV=4 -> an stays 1111 for cycles 1 and 2 after release, then an=1110.
2. Scan order: TICK_DIV=4, value_in=16'h1234 held for two frames.
   - Second frame bcd sequence: 4,3,2,1, each held 4 cycles.
   - an sequence: 1110,1101,1011,0111, each transition exactly 1 cycle after the corresponding bcd change.
   - frame_start pulses every 16 cycles.
3. Frame latch: change value_in 16'h1234 -> 16'h5678 during the digit-1 slot -> remaining slots still show 3,2,1. Next frame shows 8,7,6,5, starting the cycle after frame_start.
4. Leading zeros: value_in=16'h0042.
   - With LEADING_ZERO_BLANK_EN: bcd = 2,4,F,F.
   - Without: bcd = 2,4,0,0.
   - value_in=16'h0000 with macro: bcd = 0,F,F,F.
5. Enable: drop en mid-slot -> bcd=F next cycle, an=1111 two cycles later; frame_start cadence unchanged. Raise en -> an resumes on the current digit within 2 cycles.
6. Invalid digits and async reset: value_in=16'hA9F0 -> bcd = 0,F,9,A passed through. Assert rst_n mid-slot between clock edges -> an=1111, bcd=F without any clk edge.
